// File: rtl/fp64_seq_pkg.sv
// Shared state encoding and exponent field bounds for the fp64 pair sequencer.
package fp64_seq_pkg;
  typedef enum logic [2:0] {IDLE, RDLO, RDHI, EXEC, WBLO, WBHI, DONE} state_t;
  localparam int EXP_MSB = 62;
  localparam int EXP_LSB = 52;
endpackage

// File: rtl/fp64_zero_bypass.sv
// Result select that passes the other operand through when one has a zero exponent,
// since the adder assumes an implicit leading one.
module fp64_zero_bypass
  import fp64_seq_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic [2*WORD-1:0] srcA,
  input  logic [2*WORD-1:0] srcB,
  input  logic [2*WORD-1:0] sum,
  output logic [2*WORD-1:0] res
);
  always_comb begin
    res = sum;
    if (srcA[EXP_MSB:EXP_LSB] == '0)      res = srcB;
    else if (srcB[EXP_MSB:EXP_LSB] == '0) res = srcA;
  end
endmodule

// File: rtl/fp64_pair_sequencer.sv
// Gathers two fp64 operands from even/odd register pairs, holds them for the external
// adder, and writes the result back in two halves. FP64_SEQ_ZERO_BYPASS_EN enables zero bypass.
module fp64_pair_sequencer
  import fp64_seq_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int WORD   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [REG_AW-1:0]   rn,
  input  logic [REG_AW-1:0]   rm,
  input  logic [REG_AW-1:0]   rd,
  output logic [REG_AW-1:0]   ra1,
  output logic [REG_AW-1:0]   ra2,
  input  logic [WORD-1:0]     rd1,
  input  logic [WORD-1:0]     rd2,
  output logic [2*WORD-1:0]   srcA,
  output logic [2*WORD-1:0]   srcB,
  input  logic [2*WORD-1:0]   sum,
  output logic [REG_AW-1:0]   wa,
  output logic [WORD-1:0]     wd,
  output logic                we,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam logic [REG_AW-1:0] ONE = REG_AW'(1);

  state_t state, stateNext;
  logic [REG_AW-1:0] rnQ, rmQ, rdQ;
  logic              errQ;
  logic [2*WORD-1:0] result, resultNext;

`ifdef FP64_SEQ_ZERO_BYPASS_EN
  fp64_zero_bypass #(.WORD(WORD)) uBypass (
    .srcA(srcA), .srcB(srcB), .sum(sum), .res(resultNext)
  );
`else
  assign resultNext = sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rnQ    <= '0;
      rmQ    <= '0;
      rdQ    <= '0;
      errQ   <= 1'b0;
      srcA   <= '0;
      srcB   <= '0;
      result <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (start) begin
          rnQ  <= rn;
          rmQ  <= rm;
          rdQ  <= rd;
          errQ <= rn[0] | rm[0] | rd[0];
        end
        RDLO: begin
          srcA[WORD-1:0] <= rd1;
          srcB[WORD-1:0] <= rd2;
        end
        RDHI: begin
          srcA[2*WORD-1:WORD] <= rd1;
          srcB[2*WORD-1:WORD] <= rd2;
        end
        EXEC:    result <= resultNext;
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    ra1  = '0;
    ra2  = '0;
    wa   = '0;
    wd   = '0;
    we   = 1'b0;
    busy = (state != IDLE);
    done = 1'b0;
    err  = 1'b0;
    case (state)
      IDLE: if (start) stateNext = (rn[0] | rm[0] | rd[0]) ? DONE : RDLO;
      RDLO: begin
        ra1 = rnQ;
        ra2 = rmQ;
        stateNext = RDHI;
      end
      RDHI: begin
        ra1 = rnQ + ONE;
        ra2 = rmQ + ONE;
        stateNext = EXEC;
      end
      EXEC: stateNext = WBLO;
      WBLO: begin
        we = 1'b1;
        wa = rdQ;
        wd = result[WORD-1:0];
        stateNext = WBHI;
      end
      WBHI: begin
        we = 1'b1;
        wa = rdQ + ONE;
        wd = result[2*WORD-1:WORD];
        stateNext = DONE;
      end
      DONE: begin
        done = 1'b1;
        err  = errQ;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp64_pair_sequencer.sv
// Directed bench: register file and fp64 adder modelled around the sequencer.
module tb_fp64_pair_sequencer;
  localparam int REG_AW = 4;
  localparam int WORD   = 32;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [REG_AW-1:0] rn = '0, rm = '0, rd = '0;
  logic [REG_AW-1:0] ra1, ra2, wa;
  logic [WORD-1:0]   rd1, rd2, wd;
  logic [2*WORD-1:0] srcA, srcB, sum;
  logic we, busy, done, err;

  fp64_pair_sequencer #(.REG_AW(REG_AW), .WORD(WORD)) dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .rd(rd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .srcA(srcA), .srcB(srcB),
    .sum(sum), .wa(wa), .wd(wd), .we(we), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [WORD-1:0] regs [16];
  logic ldEn = 1'b0;
  logic [REG_AW-1:0] ldA = '0;
  logic [WORD-1:0] ldD = '0;
  int wrA[$];
  logic [WORD-1:0] wrD[$];
  logic [REG_AW-1:0] ra2Hist [21];

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign sum = $realtobits($bitstoreal(srcA) + $bitstoreal(srcB));

  always @(posedge clk) begin
    if (we) begin
      regs[wa] <= wd;
      wrA.push_back(int'(wa));
      wrD.push_back(wd);
    end else if (ldEn) regs[ldA] <= ldD;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic loadPair(input logic [REG_AW-1:0] b, input logic [63:0] v);
    @(negedge clk); ldEn = 1'b1; ldA = b;              ldD = v[31:0];
    @(negedge clk);              ldA = b + REG_AW'(1); ldD = v[63:32];
    @(negedge clk); ldEn = 1'b0;
  endtask

  // Launches one request; injA/injB are cycle numbers at which a stray start is raised.
  task automatic runOp(input logic [REG_AW-1:0] a, b, c, input int injA, injB,
                       output int lat, output logic errD, output int busyN);
    wrA.delete(); wrD.delete();
    lat = 0; errD = 1'b0; busyN = 0;
    for (int k = 0; k <= 20; k++) ra2Hist[k] = '0;
    @(negedge clk); rn = a; rm = b; rd = c; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      ra2Hist[i] = ra2;
      if (busy) busyN++;
      if (done) begin lat = i; errD = err; start = 1'b0; break; end
      start = (i == injA) || (i == injB);
    end
    start = 1'b0;
  endtask

  int lat, busyN, extra;
  logic errD;

  initial begin
    #2;
    chk("rst busy", 64'(busy), 0);
    chk("rst done", 64'(done), 0);
    chk("rst we",   64'(we),   0);
    chk("rst ra1",  64'(ra1),  0);
    chk("rst srcA", srcA, 0);
    @(negedge clk); reset = 1'b1;

    // 1.0 + 1.0
    loadPair(0, 64'h3FF0000000000000);
    loadPair(2, 64'h3FF0000000000000);
    runOp(0, 2, 4, 0, 0, lat, errD, busyN);
    chk("t1 latency", 64'(lat), 6);
    chk("t1 err",     64'(errD), 0);
    chk("t1 busy",    64'(busyN), 6);
    chk("t1 nwr",     64'(wrA.size()), 2);
    chk("t1 wa0",     64'(wrA[0]), 4);
    chk("t1 wd0",     64'(wrD[0]), 64'h0);
    chk("t1 wa1",     64'(wrA[1]), 5);
    chk("t1 wd1",     64'(wrD[1]), 64'h40000000);
    chk("t1 srcA",    srcA, 64'h3FF0000000000000);

    // odd base rejected
    runOp(1, 2, 4, 0, 0, lat, errD, busyN);
    chk("t2 latency", 64'(lat), 1);
    chk("t2 err",     64'(errD), 1);
    chk("t2 busy",    64'(busyN), 1);
    chk("t2 nwr",     64'(wrA.size()), 0);
    @(negedge clk);
    chk("t2 idle",    64'(busy), 0);
    chk("t2 srcA hold", srcA, 64'h3FF0000000000000);

    // destination overlaps operand A: 1.5 + 0.5
    loadPair(0, 64'h3FF8000000000000);
    loadPair(2, 64'h3FE0000000000000);
    runOp(0, 2, 0, 0, 0, lat, errD, busyN);
    chk("t3 latency", 64'(lat), 6);
    chk("t3 R0",   64'(regs[0]), 64'h0);
    chk("t3 R1",   64'(regs[1]), 64'h40000000);
    chk("t3 srcA", srcA, 64'h3FF8000000000000);

    // pair index at top of register file
    loadPair(14, 64'h3FF0000000000000);
    runOp(2, 14, 6, 0, 0, lat, errD, busyN);
    chk("t4 ra2 lo",   64'(ra2Hist[1]), 14);
    chk("t4 ra2 hi",   64'(ra2Hist[2]), 15);
    chk("t4 ra2 exec", 64'(ra2Hist[3]), 0);
    chk("t4 R7",       64'(regs[7]), 64'h3FF80000);

    // stray starts in RDHI and WBLO
    runOp(0, 2, 10, 2, 4, lat, errD, busyN);
    chk("t5 latency", 64'(lat), 6);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("t5 extra done", 64'(extra), 0);
    chk("t5 nwr",        64'(wrA.size()), 2);

    // reset during WBLO
    loadPair(8, 64'hDEADBEEFCAFEF00D);
    wrA.delete(); wrD.delete();
    @(negedge clk); rn = 0; rm = 2; rd = 8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6 we wblo", 64'(we), 1);
    reset = 1'b0;
    #1;
    chk("t6 we rst",   64'(we), 0);
    chk("t6 busy rst", 64'(busy), 0);
    @(negedge clk); reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6 nwr", 64'(wrA.size()), 0);
    chk("t6 R8",  64'(regs[8]), 64'hCAFEF00D);
    chk("t6 R9",  64'(regs[9]), 64'hDEADBEEF);

`ifdef FP64_SEQ_ZERO_BYPASS_EN
    loadPair(0, 64'h0);
    loadPair(2, 64'h4008000000000000);
    runOp(0, 2, 12, 0, 0, lat, errD, busyN);
    chk("byp R12", 64'(regs[12]), 64'h0);
    chk("byp R13", 64'(regs[13]), 64'h40080000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp64_pair_sequencer.md
Name: fp64_pair_sequencer

Overview:
Multicycle sequencer upstream and downstream of the combinational double-precision adder.
Gathers two 64-bit operands from the 32-bit register file as even/odd register pairs, one word per read port per cycle.
Holds srcA/srcB stable while the adder settles, registers its result, and writes it back in two 32-bit halves.
Sits between the multicycle controller (start/done) and the register file ports; the adder is instantiated alongside, not inside.

Parameters:
REG_AW, 4, register address width; pair index wraps mod 2**REG_AW.
WORD, 32, register file data width; the double is 2*WORD bits.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
rn  in  REG_AW  base register of operand A (low word); Rn+1 holds the high word
rm  in  REG_AW  base register of operand B
rd  in  REG_AW  base register of the destination pair
ra1  out  REG_AW  register file read address, port 1
ra2  out  REG_AW  register file read address, port 2
rd1  in  WORD  register file read data, port 1 (combinational read)
rd2  in  WORD  register file read data, port 2
srcA  out  2*WORD  operand A to the adder
srcB  out  2*WORD  operand B to the adder
sum  in  2*WORD  adder result
wa  out  REG_AW  write address
wd  out  WORD  write data
we  out  1  write enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = request rejected

Behaviour:
- Reset values: all outputs 0; state IDLE; operand and result registers cleared. Asynchronous reset aborts any operation immediately, with no partial writeback after release.
- IDLE: on start=1, latch rn/rm/rd.
  - If any latched index is odd, go to DONE with err=1.
  - Otherwise go to RDLO.
  - start is ignored in all other states.
- RDLO: ra1=rn, ra2=rm; at the clock edge srcA[WORD-1:0]<=rd1 and srcB[WORD-1:0]<=rd2. Next state RDHI.
- RDHI: ra1=rn+1, ra2=rm+1 (REG_AW-bit add, wraps); capture the upper words. Next state EXEC.
- EXEC: srcA/srcB are stable; capture sum into the result register at the clock edge. Next state WBLO.
- WBLO: we=1, wa=rd, wd=result[WORD-1:0]. Next state WBHI.
- WBHI: we=1, wa=rd+1, wd=result[2*WORD-1:WORD]. Next state DONE.
- DONE: done=1 for one cycle; err reflects the rejection cause. Next state IDLE; start may be accepted in the following IDLE cycle.
- Latency: start edge to done = 6 cycles on the normal path, 1 cycle on the error path.
- srcA/srcB hold their values until the next accepted request.
- ra1/ra2 are 0 outside RDLO/RDHI; we is 0 outside WBLO/WBHI.
- Register overlap is legal: with rd==rn or rd==rm, all reads complete before the first write, so operands are unaffected.
- err stays 0 on the normal path.

Optional Feature:
Macro: FP64_SEQ_ZERO_BYPASS_EN
- With the macro defined: in EXEC, if srcA[62:52]==0 the result register captures srcB instead of sum; else if srcB[62:52]==0 it captures srcA. This covers the adder's implicit-one assumption for zero/denormal operands.
- Without the macro: the result register always captures sum.

Decomposition:
- Package fp64_seq_pkg: state enum (IDLE, RDLO, RDHI, EXEC, WBLO, WBHI, DONE); localparams EXP_MSB=62 and EXP_LSB=52.
- Optional sub-module fp64_zero_bypass: a combinational mux used only under the macro.
- Everything else stays flat.

Test Plan:
1. Normal path: R0/R1=1.0 (0x3FF0000000000000), R2/R3=1.0, start with rn=0, rm=2, rd=4 -> done at cycle 6, err=0; writes are R4=0x00000000 then R5=0x40000000 (2.0).
2. Odd index: start with rn=1 -> done on the next cycle with err=1; we never asserts; busy high for exactly 1 cycle.
3. Overlap: rd=rn=0 with operands 1.5 and 0.5 -> R0/R1 become 0x4000000000000000; srcA upper word is still the original 0x3FF80000 when it is captured.
4. Wrap: REG_AW=4, rm=14 -> ra2 reads 14 in RDLO and 15 in RDHI; no out-of-range address is ever driven.
5. start pulsed during RDHI and during WBLO -> ignored; exactly one done pulse results.
6. Reset asserted in WBLO -> we drops to 0 immediately and no WBHI write occurs. With FP64_SEQ_ZERO_BYPASS_EN defined, srcA=0 and srcB=3.0 -> the written-back value is 3.0.
